// File: rtl/core_pkg.sv
// Shared types for the ID-stage hazard controller: FSM states, forwarding selects and
// the shadow-pipe entry.
package core_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        HALT = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } shadow_t;

    // The youngest producer wins when both EX/MEM and MEM/WB write the same register.
    function automatic logic [1:0] fwd_sel(logic ex_hit, logic mem_hit);
        if (ex_hit) begin
            return FWD_EXMEM;
        end else if (mem_hit) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one decoded source operand against the EX and MEM shadow entries.
module hazard_match
    import core_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       use_rs,
    input  shadow_t    ex,
    input  shadow_t    mem,
    output logic       ex_hit,
    output logic       ex_load_hit,
    output logic       mem_hit
);

    // x0 is never a real producer, so a zero index can never match.
    logic rs_live;
    assign rs_live = use_rs && (rs != 5'd0);

    assign ex_hit      = rs_live && ex.wr && (ex.rd == rs);
    assign ex_load_hit = ex_hit && ex.ld;
    assign mem_hit     = rs_live && mem.wr && (mem.rd == rs);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-side hazard control: load-use stalls, redirect flushes, memory-wait freeze with a
// watchdog, and registered EX forwarding selects.
module id_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state_q;
    logic [WCNT_W-1:0] wait_q;
    logic [WCNT_W-1:0] wait_inc;
    logic              mem_fault_q;
    shadow_t           ex_q, mem_q, ex_d;
    logic [1:0]        fwd_a_q, fwd_b_q;
    logic [CNT_W-1:0]  stall_q;

    logic a_ex_hit, a_ex_load_hit, a_mem_hit;
    logic b_ex_hit, b_ex_load_hit, b_mem_hit;
    logic freeze, redirect_act, load_use_act, bubble;

    hazard_match u_match_a (
        .rs          (id_rs1),
        .use_rs      (id_use_rs1),
        .ex          (ex_q),
        .mem         (mem_q),
        .ex_hit      (a_ex_hit),
        .ex_load_hit (a_ex_load_hit),
        .mem_hit     (a_mem_hit)
    );

    hazard_match u_match_b (
        .rs          (id_rs2),
        .use_rs      (id_use_rs2),
        .ex          (ex_q),
        .mem         (mem_q),
        .ex_hit      (b_ex_hit),
        .ex_load_hit (b_ex_load_hit),
        .mem_hit     (b_mem_hit)
    );

    // Priority: HALT/freeze beats redirect, which beats load-use.
    always_comb begin
        freeze       = (mem_req && !dmem_ready) || (state_q == HALT);
        redirect_act = ex_redirect && !freeze;
        load_use_act = (a_ex_load_hit || b_ex_load_hit) && !freeze && !ex_redirect;
        bubble       = redirect_act || load_use_act;

        pc_write    = !freeze && !load_use_act;
        ifid_write  = !freeze && !load_use_act;
        ifid_flush  = redirect_act;
        idex_flush  = bubble;
        pipe_freeze = freeze;

        ex_d = '0;
        if (!bubble) begin
            ex_d.rd = id_rd;
            ex_d.wr = id_reg_write && id_valid;
            ex_d.ld = id_mem_read && id_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (!freeze) begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            fwd_a_q <= (bubble || !id_valid) ? FWD_RF : fwd_sel(a_ex_hit, a_mem_hit);
            fwd_b_q <= (bubble || !id_valid) ? FWD_RF : fwd_sel(b_ex_hit, b_mem_hit);
        end
    end

    assign wait_inc = wait_q + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            wait_q      <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_req && !dmem_ready) begin
                        state_q <= WAIT;
                        wait_q  <= '0;
                    end
                end
                WAIT: begin
                    if (dmem_ready) begin
                        state_q <= RUN;
                    end else begin
                        wait_q <= wait_inc;
                        if (wait_inc == WAIT_LAST) begin
                            state_q     <= HALT;
                            mem_fault_q <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    mem_fault_q <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((freeze || load_use_act) && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign mem_fault   = mem_fault_q;
    assign stall_count = stall_q;

endmodule
